// File: rtl/hilo_mdu_ctrl_pkg.sv
// hilo_mdu_ctrl_pkg
// Shared definitions for the EX-stage multiply/divide controller:
//   - MDU_OP_* op_code encodings (0 = no MDU op)
//   - controller state encoding
//   - stall and divider start/stop level constants
//   - helper that decodes the signedness of an op_code
package hilo_mdu_ctrl_pkg;

    localparam logic [2:0] MDU_OP_NONE  = 3'd0;
    localparam logic [2:0] MDU_OP_MULT  = 3'd1;
    localparam logic [2:0] MDU_OP_MULTU = 3'd2;
    localparam logic [2:0] MDU_OP_DIV   = 3'd3;
    localparam logic [2:0] MDU_OP_DIVU  = 3'd4;
    localparam logic [2:0] MDU_OP_MTHI  = 3'd5;
    localparam logic [2:0] MDU_OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {
        MDU_IDLE     = 2'd0,
        MDU_MUL_WAIT = 2'd1,
        MDU_DIV_RUN  = 2'd2,
        MDU_DONE     = 2'd3
    } mdu_state_t;

    localparam logic STOP      = 1'b1;
    localparam logic NO_STOP   = 1'b0;
    localparam logic DIV_START = 1'b1;
    localparam logic DIV_STOP  = 1'b0;

    // MULT and DIV are the signed flavours; everything else is unsigned.
    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == MDU_OP_MULT) || (op == MDU_OP_DIV);
    endfunction

endpackage

// File: rtl/hilo_reg.sv
// hilo_reg
// HI/LO architectural register pair with independent write enables.
// Writes land on the clock edge and are visible the following cycle.
// Ports:
//   clk, rst        clock, synchronous active-high reset (clears HI and LO)
//   hi_we, hi_wd    HI write enable / data
//   lo_we, lo_wd    LO write enable / data
//   hi, lo          current register contents
module hilo_reg #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hi_we,
    input  logic [DATA_W-1:0] hi_wd,
    input  logic              lo_we,
    input  logic [DATA_W-1:0] lo_wd,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else begin
            if (hi_we) hi <= hi_wd;
            if (lo_we) lo <= lo_wd;
        end
    end

endmodule

// File: rtl/hilo_mdu_ctrl.sv
// hilo_mdu_ctrl
// Sequencing controller for the EX-stage multiply/divide resources.
// Issues MULT/MULTU to a fixed-latency mul core and DIV/DIVU to a
// start/ready div core, owns HI/LO, stalls EX while a long op is
// outstanding, handles flush (annul) and ignores a held instruction that
// has already completed (DONE) until EX advances.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   op_valid, op_code             MDU op presented by EX
//   op_src1, op_src2              rs / rt operand values
//   ex_advance                    EX loads a new instruction this cycle
//   flush                         discard the in-flight op
//   stallreq_o, busy_o            EX hold request, state != IDLE
//   hi_o, lo_o                    HI/LO registers
//   mul_signed_o, mul_ina_o/inb_o mul core operands; mul_result_i {hi,lo}
//   div_start_o, div_annul_o      div core control
//   div_signed_o, div_opdata*_o   div core operands
//   div_ready_i, div_result_i     div core completion, {remainder,quotient}
module hilo_mdu_ctrl
    import hilo_mdu_ctrl_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int MUL_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                op_valid,
    input  logic [2:0]          op_code,
    input  logic [DATA_W-1:0]   op_src1,
    input  logic [DATA_W-1:0]   op_src2,
    input  logic                ex_advance,
    input  logic                flush,
    output logic                stallreq_o,
    output logic                busy_o,
    output logic [DATA_W-1:0]   hi_o,
    output logic [DATA_W-1:0]   lo_o,
    output logic                mul_signed_o,
    output logic [DATA_W-1:0]   mul_ina_o,
    output logic [DATA_W-1:0]   mul_inb_o,
    input  logic [2*DATA_W-1:0] mul_result_i,
    output logic                div_start_o,
    output logic                div_annul_o,
    output logic                div_signed_o,
    output logic [DATA_W-1:0]   div_opdata1_o,
    output logic [DATA_W-1:0]   div_opdata2_o,
    input  logic                div_ready_i,
    input  logic [2*DATA_W-1:0] div_result_i
);

    localparam int CNT_W = (MUL_LAT < 2) ? 1 : $clog2(MUL_LAT + 1);

    mdu_state_t        state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] src1_q;
    logic [DATA_W-1:0] src2_q;
    logic              signed_q;

    logic              issue_mul;
    logic              issue_div;
    logic              complete;
    logic              hi_we;
    logic              lo_we;
    logic [DATA_W-1:0] hi_wd;
    logic [DATA_W-1:0] lo_wd;
    logic              use_live;
    logic              live_signed;

    // Stall, start and HI/LO writes must react in the issue cycle itself,
    // so they are decoded combinationally from state and the presented op.
    always_comb begin
        // NOTE: every output of this block gets a default first; no latches.
        stallreq_o  = NO_STOP;
        div_start_o = DIV_STOP;
        div_annul_o = 1'b0;
        issue_mul   = 1'b0;
        issue_div   = 1'b0;
        complete    = 1'b0;
        hi_we       = 1'b0;
        lo_we       = 1'b0;
        hi_wd       = '0;
        lo_wd       = '0;
        if (!rst) begin
            if (flush) begin
                div_annul_o = (state == MDU_DIV_RUN);
            end else begin
                unique case (state)
                    MDU_IDLE: begin
                        if (op_valid) begin
                            case (op_code)
                                MDU_OP_MULT, MDU_OP_MULTU: begin
                                    stallreq_o = STOP;
                                    issue_mul  = 1'b1;
                                end
                                MDU_OP_DIV, MDU_OP_DIVU: begin
                                    // Divide by zero: leave HI/LO alone, no core run.
                                    if (op_src2 != '0) begin
                                        stallreq_o  = STOP;
                                        div_start_o = DIV_START;
                                        issue_div   = 1'b1;
                                    end else begin
                                        complete = 1'b1;
                                    end
                                end
                                MDU_OP_MTHI: begin
                                    hi_we    = 1'b1;
                                    hi_wd    = op_src1;
                                    complete = 1'b1;
                                end
                                MDU_OP_MTLO: begin
                                    lo_we    = 1'b1;
                                    lo_wd    = op_src1;
                                    complete = 1'b1;
                                end
                                default: complete = 1'b1;
                            endcase
                        end
                    end
                    MDU_MUL_WAIT: begin
                        if (cnt == CNT_W'(1)) begin
                            hi_we    = 1'b1;
                            lo_we    = 1'b1;
                            hi_wd    = mul_result_i[2*DATA_W-1:DATA_W];
                            lo_wd    = mul_result_i[DATA_W-1:0];
                            complete = 1'b1;
                        end else begin
                            stallreq_o = STOP;
                        end
                    end
                    MDU_DIV_RUN: begin
                        if (div_ready_i) begin
                            hi_we    = 1'b1;
                            lo_we    = 1'b1;
                            hi_wd    = div_result_i[2*DATA_W-1:DATA_W];
                            lo_wd    = div_result_i[DATA_W-1:0];
                            complete = 1'b1;
                        end else begin
                            stallreq_o  = STOP;
                            div_start_o = DIV_START;
                        end
                    end
                    MDU_DONE: ;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: operand latches are reset too so the core inputs are
            // deterministic out of reset, not only the state register.
            state    <= MDU_IDLE;
            cnt      <= '0;
            src1_q   <= '0;
            src2_q   <= '0;
            signed_q <= 1'b0;
        end else if (flush) begin
            state <= MDU_IDLE;
        end else begin
            if (issue_mul || issue_div) begin
                src1_q   <= op_src1;
                src2_q   <= op_src2;
                signed_q <= live_signed;
            end
            if (issue_mul) begin
                cnt   <= CNT_W'(MUL_LAT);
                state <= MDU_MUL_WAIT;
            end else if (issue_div) begin
                state <= MDU_DIV_RUN;
            end else if (complete) begin
                state <= ex_advance ? MDU_IDLE : MDU_DONE;
            end else if (state == MDU_DONE && ex_advance) begin
                state <= MDU_IDLE;
            end
            if (state == MDU_MUL_WAIT) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    // Cores see the live operands in the issue cycle, latched ones afterwards.
    assign use_live      = (state == MDU_IDLE);
    assign live_signed   = is_signed_op(op_code);
    assign mul_signed_o  = use_live ? live_signed : signed_q;
    assign mul_ina_o     = use_live ? op_src1 : src1_q;
    assign mul_inb_o     = use_live ? op_src2 : src2_q;
    assign div_signed_o  = use_live ? live_signed : signed_q;
    assign div_opdata1_o = use_live ? op_src1 : src1_q;
    assign div_opdata2_o = use_live ? op_src2 : src2_q;
    assign busy_o        = (state != MDU_IDLE);

    hilo_reg #(.DATA_W(DATA_W)) u_hilo_reg (
        .clk   (clk),
        .rst   (rst),
        .hi_we (hi_we),
        .hi_wd (hi_wd),
        .lo_we (lo_we),
        .lo_wd (lo_wd),
        .hi    (hi_o),
        .lo    (lo_o)
    );

endmodule

// File: tb/tb_hilo_mdu_ctrl.sv
// tb_hilo_mdu_ctrl
// Directed bench for hilo_mdu_ctrl with a registered one-cycle mul model
// and a div model that raises ready 33 cycles after start.
module tb_hilo_mdu_ctrl;
    import hilo_mdu_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic [2:0]  op_code;
    logic [31:0] op_src1, op_src2;
    logic        ex_advance, flush;
    logic        stallreq_o, busy_o;
    logic [31:0] hi_o, lo_o;
    logic        mul_signed_o;
    logic [31:0] mul_ina_o, mul_inb_o;
    logic [63:0] mul_result_i;
    logic        div_start_o, div_annul_o, div_signed_o;
    logic [31:0] div_opdata1_o, div_opdata2_o;
    logic        div_ready_i;
    logic [63:0] div_result_i;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hilo_mdu_ctrl #(.DATA_W(32), .MUL_LAT(1)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code),
        .op_src1(op_src1), .op_src2(op_src2), .ex_advance(ex_advance),
        .flush(flush), .stallreq_o(stallreq_o), .busy_o(busy_o),
        .hi_o(hi_o), .lo_o(lo_o), .mul_signed_o(mul_signed_o),
        .mul_ina_o(mul_ina_o), .mul_inb_o(mul_inb_o), .mul_result_i(mul_result_i),
        .div_start_o(div_start_o), .div_annul_o(div_annul_o),
        .div_signed_o(div_signed_o), .div_opdata1_o(div_opdata1_o),
        .div_opdata2_o(div_opdata2_o), .div_ready_i(div_ready_i),
        .div_result_i(div_result_i)
    );

    // Mul core model: product of the operands presented one edge earlier.
    always @(posedge clk) begin
        if (mul_signed_o)
            mul_result_i <= {{32{mul_ina_o[31]}}, mul_ina_o} * {{32{mul_inb_o[31]}}, mul_inb_o};
        else
            mul_result_i <= {32'd0, mul_ina_o} * {32'd0, mul_inb_o};
    end

    // Div core model: ready when 33 start cycles have elapsed.
    int unsigned dcnt;
    assign div_ready_i = (dcnt == 33);
    always @(posedge clk) begin
        if (rst || div_annul_o)                dcnt <= 0;
        else if (div_start_o && !div_ready_i) dcnt <= dcnt + 1;
        else                                   dcnt <= 0;
    end

    logic [31:0] dq, dr;
    always @* begin
        dq = '0;
        dr = '0;
        if (div_opdata2_o != 0) begin
            if (div_signed_o) begin
                dq = $signed(div_opdata1_o) / $signed(div_opdata2_o);
                dr = $signed(div_opdata1_o) % $signed(div_opdata2_o);
            end else begin
                dq = div_opdata1_o / div_opdata2_o;
                dr = div_opdata1_o % div_opdata2_o;
            end
        end
        div_result_i = {dr, dq};
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input logic v, input logic [2:0] op, input logic [31:0] s1,
                         input logic [31:0] s2, input logic adv, input logic fl);
        op_valid = v; op_code = op; op_src1 = s1; op_src2 = s2;
        ex_advance = adv; flush = fl;
    endtask

    typedef struct {
        logic        v;
        logic [2:0]  op;
        logic [31:0] s1, s2;
        logic        adv, fl;
        logic        e_stall, e_busy, e_start, e_msigned;
        logic [31:0] e_hi, e_lo;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic [2:0] op, input logic [31:0] s1,
                                input logic [31:0] s2, input logic adv, input logic fl,
                                input logic st, input logic bz, input logic ds,
                                input logic ms, input logic [31:0] hi, input logic [31:0] lo);
        vec_t r;
        r.v = v; r.op = op; r.s1 = s1; r.s2 = s2; r.adv = adv; r.fl = fl;
        r.e_stall = st; r.e_busy = bz; r.e_start = ds; r.e_msigned = ms;
        r.e_hi = hi; r.e_lo = lo;
        return r;
    endfunction

    vec_t tbl[24];

    initial begin
        // Each row is one cycle: inputs, then outputs expected before its edge.
        tbl[0]  = mk(0, MDU_OP_NONE,  0, 0, 1, 0,  0, 0, 0, 0, 32'h0, 32'h0);
        tbl[1]  = mk(1, MDU_OP_MTHI,  32'h11, 0, 1, 0,  0, 0, 0, 0, 32'h0, 32'h0);
        tbl[2]  = mk(1, MDU_OP_MTLO,  32'h22, 0, 1, 0,  0, 0, 0, 0, 32'h11, 32'h0);
        tbl[3]  = mk(1, MDU_OP_DIVU,  100, 0, 1, 0,  0, 0, 0, 0, 32'h11, 32'h22);
        tbl[4]  = mk(0, MDU_OP_NONE,  0, 0, 1, 0,  0, 0, 0, 0, 32'h11, 32'h22);
        tbl[5]  = mk(1, MDU_OP_MULT,  32'hFFFFFFFE, 3, 0, 0,  1, 0, 0, 1, 32'h11, 32'h22);
        tbl[6]  = mk(1, MDU_OP_MULT,  32'hFFFFFFFE, 3, 1, 0,  0, 1, 0, 1, 32'h11, 32'h22);
        tbl[7]  = mk(0, MDU_OP_NONE,  0, 0, 1, 0,  0, 0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFA);
        tbl[8]  = mk(1, MDU_OP_MULTU, 32'hFFFFFFFE, 3, 0, 0,  1, 0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFA);
        tbl[9]  = mk(1, MDU_OP_MULTU, 32'hFFFFFFFE, 3, 1, 0,  0, 1, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFA);
        tbl[10] = mk(0, MDU_OP_NONE,  0, 0, 1, 0,  0, 0, 0, 0, 32'h2, 32'hFFFFFFFA);
        tbl[11] = mk(1, MDU_OP_MULT,  2, 3, 0, 0,  1, 0, 0, 1, 32'h2, 32'hFFFFFFFA);
        tbl[12] = mk(1, MDU_OP_MULT,  2, 3, 0, 0,  0, 1, 0, 1, 32'h2, 32'hFFFFFFFA);
        tbl[13] = mk(1, MDU_OP_MULT,  2, 3, 0, 0,  0, 1, 0, 1, 32'h0, 32'h6);
        tbl[14] = mk(1, MDU_OP_MULT,  2, 3, 0, 0,  0, 1, 0, 1, 32'h0, 32'h6);
        tbl[15] = mk(1, MDU_OP_MULT,  2, 3, 1, 0,  0, 1, 0, 1, 32'h0, 32'h6);
        tbl[16] = mk(1, MDU_OP_MTLO,  32'h1234, 0, 1, 0,  0, 0, 0, 0, 32'h0, 32'h6);
        tbl[17] = mk(0, MDU_OP_NONE,  0, 0, 1, 0,  0, 0, 0, 0, 32'h0, 32'h1234);
        tbl[18] = mk(1, 3'd7,         0, 0, 0, 0,  0, 0, 0, 0, 32'h0, 32'h1234);
        tbl[19] = mk(0, MDU_OP_NONE,  0, 0, 1, 0,  0, 1, 0, 1, 32'h0, 32'h1234);
        tbl[20] = mk(0, MDU_OP_NONE,  0, 0, 1, 0,  0, 0, 0, 0, 32'h0, 32'h1234);
        tbl[21] = mk(1, MDU_OP_MULT,  5, 5, 0, 0,  1, 0, 0, 1, 32'h0, 32'h1234);
        tbl[22] = mk(1, MDU_OP_MULT,  5, 5, 0, 1,  0, 1, 0, 1, 32'h0, 32'h1234);
        tbl[23] = mk(0, MDU_OP_NONE,  0, 0, 1, 0,  0, 0, 0, 0, 32'h0, 32'h1234);

        rst = 1'b1;
        apply(0, MDU_OP_NONE, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_hi", 64'(hi_o), 64'h0);
        check("rst_lo", 64'(lo_o), 64'h0);
        check("rst_stall", 64'(stallreq_o), 64'h0);
        check("rst_busy", 64'(busy_o), 64'h0);
        check("rst_start", 64'(div_start_o), 64'h0);
        check("rst_annul", 64'(div_annul_o), 64'h0);

        for (int i = 0; i < 24; i++) begin
            @(posedge clk); #1;
            apply(tbl[i].v, tbl[i].op, tbl[i].s1, tbl[i].s2, tbl[i].adv, tbl[i].fl);
            @(negedge clk);
            check($sformatf("r%0d_stall", i), 64'(stallreq_o), 64'(tbl[i].e_stall));
            check($sformatf("r%0d_busy", i), 64'(busy_o), 64'(tbl[i].e_busy));
            check($sformatf("r%0d_start", i), 64'(div_start_o), 64'(tbl[i].e_start));
            check($sformatf("r%0d_msigned", i), 64'(mul_signed_o), 64'(tbl[i].e_msigned));
            check($sformatf("r%0d_hi", i), 64'(hi_o), 64'(tbl[i].e_hi));
            check($sformatf("r%0d_lo", i), 64'(lo_o), 64'(tbl[i].e_lo));
        end

        // DIV -7 / 2: stall and start high cycles 0..32, ready on cycle 33.
        begin
            int  ready_cyc;
            logic all_high;
            ready_cyc = -1;
            all_high  = 1'b1;
            @(posedge clk); #1;
            apply(1, MDU_OP_DIV, 32'hFFFFFFF9, 2, 0, 0);
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (div_ready_i) begin
                    ready_cyc = k;
                    check("div_ready_stall", 64'(stallreq_o), 64'h0);
                    check("div_ready_start", 64'(div_start_o), 64'h0);
                    break;
                end
                if (!stallreq_o || !div_start_o) all_high = 1'b0;
                @(posedge clk); #1;
            end
            check("div_ready_cycle", 64'(ready_cyc), 64'(33));
            check("div_stall_all_high", 64'(all_high), 64'h1);
            @(posedge clk); #1;
            @(negedge clk);
            check("div_done_busy", 64'(busy_o), 64'h1);
            check("div_done_stall", 64'(stallreq_o), 64'h0);
            check("div_hi", 64'(hi_o), 64'hFFFFFFFF);
            check("div_lo", 64'(lo_o), 64'hFFFFFFFD);
            @(posedge clk); #1;
            apply(1, MDU_OP_DIV, 32'hFFFFFFF9, 2, 1, 0);
            @(posedge clk); #1;
            apply(0, MDU_OP_NONE, 0, 0, 1, 0);
            @(negedge clk);
            check("div_back_idle", 64'(busy_o), 64'h0);
        end

        // DIV 50 / 5 flushed on cycle 10 of DIV_RUN.
        @(posedge clk); #1;
        apply(1, MDU_OP_DIV, 50, 5, 0, 0);
        for (int k = 1; k < 10; k++) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("fl_pre_busy", 64'(busy_o), 64'h1);
        check("fl_pre_start", 64'(div_start_o), 64'h1);
        check("fl_pre_annul", 64'(div_annul_o), 64'h0);
        @(posedge clk); #1;
        apply(0, MDU_OP_NONE, 0, 0, 1, 1);
        @(negedge clk);
        check("fl_annul", 64'(div_annul_o), 64'h1);
        check("fl_stall", 64'(stallreq_o), 64'h0);
        @(posedge clk); #1;
        apply(0, MDU_OP_NONE, 0, 0, 1, 0);
        @(negedge clk);
        check("fl_post_annul", 64'(div_annul_o), 64'h0);
        check("fl_post_stall", 64'(stallreq_o), 64'h0);
        check("fl_post_busy", 64'(busy_o), 64'h0);
        check("fl_post_hi", 64'(hi_o), 64'hFFFFFFFF);
        check("fl_post_lo", 64'(lo_o), 64'hFFFFFFFD);

        // Reset in the middle of a MULT drops it and clears HI/LO.
        @(posedge clk); #1;
        apply(1, MDU_OP_MULT, 7, 7, 0, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_stall", 64'(stallreq_o), 64'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        apply(0, MDU_OP_NONE, 0, 0, 1, 0);
        @(negedge clk);
        check("rst_mid_busy", 64'(busy_o), 64'h0);
        check("rst_mid_hi", 64'(hi_o), 64'h0);
        check("rst_mid_lo", 64'(lo_o), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/hilo_mdu_ctrl.md
Name: hilo_mdu_ctrl

Overview:
Sequencing controller for the EX-stage multiply/divide resources. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX and drives the existing mul core (fixed latency) and the existing div core (start/ready handshake). It owns the HI/LO architectural registers and raises the EX stall request while a long operation is outstanding. It also handles pipeline flush (annul) and the re-presentation of a held instruction.

Parameters:
DATA_W, 32, operand and HI/LO width
MUL_LAT, 1, cycles from operands presented to mul_result_i valid (≥1)

Ports:
clk  in  1  clock
rst  in  1  reset
op_valid  in  1  EX holds a valid MDU op
op_code  in  3  MDU_OP_* encoding
op_src1  in  DATA_W  rs value (dividend / multiplicand / MTHI-MTLO data)
op_src2  in  DATA_W  rt value (divisor / multiplier)
ex_advance  in  1  EX pipeline register loads a new instruction this cycle
flush  in  1  discard in-flight op
stallreq_o  out  1  hold EX
busy_o  out  1  state != IDLE
hi_o  out  DATA_W  HI register
lo_o  out  DATA_W  LO register
mul_signed_o  out  1  to mul core
mul_ina_o, mul_inb_o  out  DATA_W  to mul core
mul_result_i  in  2*DATA_W  {hi,lo} product
div_start_o  out  1  to div core start_i
div_annul_o  out  1  to div core annul_i
div_signed_o  out  1  to div core
div_opdata1_o, div_opdata2_o  out  DATA_W  to div core
div_ready_i  in  1  div core ready_o
div_result_i  in  2*DATA_W  {remainder,quotient}

Behaviour:
- Clocking and reset: one clock (clk); reset rst is synchronous and active-high. Priority: rst > flush > normal.
- Reset values: state=IDLE; hi_o=lo_o=0; stallreq_o=0; busy_o=0; div_start_o=div_annul_o=0; operand latches=0. Reset mid-operation drops the op; HI/LO are cleared and no annul is issued (rst also resets the div core).
- States: IDLE, MUL_WAIT, DIV_RUN, DONE.
- Core operand muxing: in IDLE, mul/div operand and signed outputs come from op_src*; in other states they come from latches captured at the issue edge.
- IDLE, op_valid=1:
  - MULT/MULTU: stallreq_o=1; latch operands; cnt<=MUL_LAT; go to MUL_WAIT.
  - DIV/DIVU with op_src2!=0: stallreq_o=1; div_start_o=1; latch operands; go to DIV_RUN.
  - DIV/DIVU with op_src2==0: no stall; HI/LO unchanged; core not started; completion this cycle.
  - MTHI/MTLO: no stall; HI or LO <= op_src1 at the edge; completion this cycle.
- MUL_WAIT: cnt decrements each cycle. stallreq_o=1 while cnt>1. When cnt==1: stallreq_o=0, {HI,LO} <= mul_result_i; completion. EX is stalled exactly MUL_LAT cycles total.
- DIV_RUN:
  - div_ready_i=0: div_start_o=1, stallreq_o=1.
  - div_ready_i=1: div_start_o=0, stallreq_o=0, HI <= div_result_i[63:32], LO <= div_result_i[31:0]; completion.
- Completion transition: go to IDLE if ex_advance=1, else go to DONE.
- DONE: stallreq_o=0; op_valid is ignored (the same instruction is still presented, so no re-issue); go to IDLE on ex_advance.
- Flush in any state: state <= IDLE, HI/LO unchanged, stallreq_o=0. div_annul_o=1 for that cycle when state==DIV_RUN.
- Read timing: HI/LO writes become visible on hi_o/lo_o the cycle after the write edge; there is no bypass.
- Signedness: mul_signed_o/div_signed_o=1 for MULT/DIV, 0 for MULTU/DIVU.
- Undefined op_code with op_valid=1: ignored and treated as a completion.

Decomposition:
- lib/defines.vh holds: MDU_OP_MULT=3'd1, MULTU=3'd2, DIV=3'd3, DIVU=3'd4, MTHI=3'd5, MTLO=3'd6 (0 = none); the MDU state encodings; the existing Stop/NoStop and DivStart/DivStop constants.
- One sub-module, hilo_reg: HI/LO storage with independent write enables and synchronous reset.

Test Plan:
- MULT 0xFFFFFFFE × 3, MUL_LAT=1 → stallreq_o high 1 cycle; next cycle hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFA.
- MULTU 0xFFFFFFFE × 3 → hi_o=0x00000002, lo_o=0xFFFFFFFA; mul_signed_o=0 throughout.
- DIV −7 / 2, div model ready on cycle 33 → stallreq_o high cycles 0–32, low on the ready cycle; then lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF; div_start_o drops with ready.
- DIVU 100 / 0 with hi=0x11, lo=0x22 → stallreq_o never asserted, div_start_o never asserted, HI/LO unchanged.
- DIV started, flush on cycle 10 of DIV_RUN → div_annul_o=1 for one cycle, stallreq_o=0 next cycle, HI/LO unchanged, state IDLE.
- MULT completes with ex_advance=0 for 3 cycles while op_valid stays 1 → state DONE, no second issue; then MTLO 0x1234 after ex_advance → lo_o=0x1234 the following cycle.
